axis_labcontrol_rx_mc: RTL and testbench

AXIS_LABCONTROL_RX_MC -- requirements
Module: axis_labcontrol_rx_mc

---
 rtl/axis_labcontrol_rx_mc.sv | 179 +++++++++++++++++
 tb/tb_axis_labcontrol_rx_mc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_labcontrol_rx_mc.sv
// ---------------------------------------------------------------------------
// axis_labcontrol_rx_mc
//   Multi-channel LabControl bus receiver. Words written by the bus master to
//   addresses BASE_ADDRESS .. BASE_ADDRESS+NUM_CH-1 are queued in one FIFO and
//   presented on an AXI-Stream master port in arrival order.
//
// Optional feature macro: LC_STROBE_FILTER_EN
//   When defined, the synchronised strobe must stay high FILTER_LEN
//   consecutive clocks before it counts as a write.
//
// Ports
//   m_axis_aclk    in   clock, all logic on the rising edge
//   m_axis_areset  in   asynchronous active-high reset
//   m_axis_tdata   out  captured {DIOA,DIOB}, resized to AXIS_DATA_WIDTH
//   m_axis_tvalid  out  FIFO non-empty
//   m_axis_tready  in   downstream accept
//   m_axis_tdest   out  channel index (DIOC - BASE_ADDRESS)
//   m_axis_tuser   out  subbus DIOD[4:2]
//   DIOA..DIOD     in   asynchronous LabControl bus (DIOD[0] strobe,
//                       DIOD[1] direction, DIOD[4:2] subbus)
//   fifo_level     out  FIFO occupancy
//   drop_count     out  words lost to FIFO full, saturating
// ---------------------------------------------------------------------------
module axis_labcontrol_rx_mc #(
    parameter int AXIS_DATA_WIDTH = 16,
    parameter int NUM_CH          = 4,
    parameter int BASE_ADDRESS    = 'h10,
    parameter int FIFO_DEPTH      = 16,
    parameter int CNT_WIDTH       = 8,
    parameter int FILTER_LEN      = 3
) (
    input  logic                                      m_axis_aclk,
    input  logic                                      m_axis_areset,
    output logic [AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] m_axis_tdest,
    output logic [2:0]                                m_axis_tuser,
    input  logic [7:0]                                DIOA,
    input  logic [7:0]                                DIOB,
    input  logic [7:0]                                DIOC,
    input  logic [7:0]                                DIOD,
    output logic [$clog2(FIFO_DEPTH):0]               fifo_level,
    output logic [CNT_WIDTH-1:0]                      drop_count
);

    localparam int TDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [8:0] ADDR_LO = 9'(BASE_ADDRESS);
    localparam logic [8:0] ADDR_HI = 9'(BASE_ADDRESS + NUM_CH - 1);

    typedef struct packed {
        logic [15:0]    data;
        logic [TDW-1:0] ch;
        logic [2:0]     sub;
    } entry_t;

    // ---------------- strobe synchroniser and edge detect ----------------
    // Sync flops and history reset to 1 so a strobe already high when reset
    // releases is treated as old and never produces a word.
    logic [1:0] sync_q, sync_d;
    logic       hist_q;
    logic       strb_f;
    logic       strb_ev;

    assign sync_d = {sync_q[0], DIOD[0]};

`ifdef LC_STROBE_FILTER_EN
    // fcnt_q counts prior consecutive high cycles, saturating at FILTER_LEN-1.
    // Once the filtered strobe is high (hist_q) it stays high until the raw
    // synchronised strobe drops, so the counter is only needed for the rise.
    logic [3:0] fcnt_q, fcnt_d;
    localparam logic [3:0] FCNT_MAX = 4'(FILTER_LEN - 1);

    always_comb begin
        fcnt_d = fcnt_q;
        if (!sync_q[1])
            fcnt_d = '0;
        else if (fcnt_q != FCNT_MAX)
            fcnt_d = fcnt_q + 4'd1;
    end

    assign strb_f = sync_q[1] & (hist_q | (fcnt_q == FCNT_MAX));

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) fcnt_q <= '0;
        else               fcnt_q <= fcnt_d;
    end
`else
    assign strb_f = sync_q[1];
`endif

    assign strb_ev = strb_f & ~hist_q;

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            sync_q <= 2'b11;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= strb_f;
        end
    end

    // ---------------- address decode and FIFO control ----------------
    logic   addr_hit;
    logic   wr_req;
    logic   full;
    logic   pop;
    logic   push;
    logic   drop;
    entry_t in_entry;
    entry_t head;

    logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]          lvl_q, lvl_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;

    assign addr_hit = ({1'b0, DIOC} >= ADDR_LO) && ({1'b0, DIOC} <= ADDR_HI);
    assign wr_req   = strb_ev & addr_hit & ~DIOD[1];
    assign full     = (lvl_q == (AW+1)'(FIFO_DEPTH));
    assign pop      = m_axis_tvalid & m_axis_tready;
    // When full, a same-cycle pop frees the slot being written.
    assign push     = wr_req & (~full | pop);
    assign drop     = wr_req & full & ~pop;

    assign in_entry.data = {DIOA, DIOB};
    assign in_entry.ch   = TDW'({1'b0, DIOC} - ADDR_LO);
    assign in_entry.sub  = DIOD[4:2];

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        lvl_d  = lvl_q;
        drop_d = drop_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        case ({push, pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
        if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            lvl_q  <= '0;
            drop_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            lvl_q  <= lvl_d;
            drop_q <= drop_d;
        end
    end

    // Storage carries no reset; the outputs are masked by tvalid instead.
    entry_t mem [FIFO_DEPTH];

    always_ff @(posedge m_axis_aclk) begin
        if (push) mem[wr_q] <= in_entry;
    end

    assign head          = mem[rd_q];
    assign m_axis_tvalid = (lvl_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? AXIS_DATA_WIDTH'(head.data) : '0;
    assign m_axis_tdest  = m_axis_tvalid ? head.ch  : '0;
    assign m_axis_tuser  = m_axis_tvalid ? head.sub : '0;
    assign fifo_level    = lvl_q;
    assign drop_count    = drop_q;

    // Reserved bus bits carry nothing for this receiver.
    logic unused_ok;
    assign unused_ok = ^{DIOD[7:5], FILTER_LEN[0]};

endmodule

// File: tb/tb_axis_labcontrol_rx_mc.sv
module tb_axis_labcontrol_rx_mc;

    localparam int DW    = 16;
    localparam int NCH   = 4;
    localparam int BASE  = 'h10;
    localparam int DEPTH = 16;
    localparam int CW    = 8;
    localparam int FLEN  = 3;
`ifdef LC_STROBE_FILTER_EN
    localparam int LAT = 3 + FLEN - 1;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic [1:0]    tdest;
    logic [2:0]    tuser;
    logic [7:0]    DIOA, DIOB, DIOC, DIOD;
    logic [4:0]    level;
    logic [CW-1:0] drops;

    int errors = 0;
    int checks = 0;

    axis_labcontrol_rx_mc #(
        .AXIS_DATA_WIDTH(DW), .NUM_CH(NCH), .BASE_ADDRESS(BASE),
        .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW), .FILTER_LEN(FLEN)
    ) dut (
        .m_axis_aclk(clk), .m_axis_areset(rst),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tdest(tdest), .m_axis_tuser(tuser),
        .DIOA(DIOA), .DIOB(DIOB), .DIOC(DIOC), .DIOD(DIOD),
        .fifo_level(level), .drop_count(drops)
    );

    always #5 clk = ~clk;

    // One complete bus write: strobe high long enough to be seen, then low
    // long enough for the edge detector to re-arm. Ends on a falling edge.
    task automatic write_word(input logic [7:0] c, input logic dir,
                              input logic [2:0] sub, input logic [15:0] d);
        @(negedge clk);
        DIOA = d[15:8]; DIOB = d[7:0]; DIOC = c;
        DIOD = {3'b000, sub, dir, 1'b1};
        repeat (LAT + 2) @(negedge clk);
        DIOD[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (tvalid !== 1'b0 || level !== 5'd0 || drops !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl: tvalid=%b level=%0d drops=%0d, want 0/0/0", tvalid, level, drops);
        end
        checks++;
        if (tdata !== 16'h0 || tdest !== 2'd0 || tuser !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: tdata=%h tdest=%0d tuser=%0d, want 0", tdata, tdest, tuser);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL reset_release: tvalid=%b level=%0d, want 0/0", tvalid, level);
        end
    endtask

    task automatic test_single;
        tready = 1'b1;
        @(negedge clk);
        DIOA = 8'hBE; DIOB = 8'hEF; DIOC = 8'h12; DIOD = {3'b000, 3'b101, 1'b0, 1'b1};
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checks++;
            if (k < LAT && tvalid !== 1'b0) begin
                errors++;
                $display("FAIL single_early: edge %0d tvalid=%b, want 0", k, tvalid);
            end else if (k == LAT && (tvalid !== 1'b1 || tdata !== 16'hBEEF ||
                                      tdest !== 2'd2 || tuser !== 3'b101)) begin
                errors++;
                $display("FAIL single_beat: tvalid=%b tdata=%h tdest=%0d tuser=%0d, want 1/beef/2/5",
                         tvalid, tdata, tdest, tuser);
            end
        end
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL single_once: tvalid=%b level=%0d, want 0/0", tvalid, level);
        end
        DIOD[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reject;
        logic [7:0] addr [3];
        logic       dir  [3];
        addr[0] = 8'h14; dir[0] = 1'b0;
        addr[1] = 8'h0F; dir[1] = 1'b0;
        addr[2] = 8'h12; dir[2] = 1'b1;
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            write_word(addr[i], dir[i], 3'd1, 16'h5A5A);
            checks++;
            if (level !== 5'd0 || tvalid !== 1'b0) begin
                errors++;
                $display("FAIL reject_%0d: level=%0d tvalid=%b, want 0/0", i, level, tvalid);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d [3];
        logic [1:0]  c [3];
        logic [2:0]  s [3];
        d[0] = 16'h1111; c[0] = 2'd3; s[0] = 3'd5;
        d[1] = 16'h2222; c[1] = 2'd0; s[1] = 3'd0;
        d[2] = 16'h3333; c[2] = 2'd1; s[2] = 3'd7;
        tready = 1'b0;
        for (int i = 0; i < 3; i++) write_word(8'(BASE) + 8'(c[i]), 1'b0, s[i], d[i]);
        tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tvalid !== 1'b1 || tdata !== d[i] || tdest !== c[i] || tuser !== s[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d: v=%b d=%h c=%0d s=%0d, want 1/%h/%0d/%0d",
                         i, tvalid, tdata, tdest, tuser, d[i], c[i], s[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (tvalid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL b2b_empty: tvalid=%b level=%0d, want 0/0", tvalid, level);
        end
    endtask

    task automatic test_overflow;
        tready = 1'b0;
        for (int i = 0; i < 18; i++)
            write_word(8'(BASE + i % 4), 1'b0, 3'(i % 8), 16'hA000 + 16'(i));
        checks++;
        if (level !== 5'd16 || drops !== 8'd2 || tvalid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: level=%0d drops=%0d tvalid=%b, want 16/2/1", level, drops, tvalid);
        end
        tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tvalid !== 1'b1 || tdata !== 16'hA000 + 16'(i) ||
                tdest !== 2'(i % 4) || tuser !== 3'(i % 8)) begin
                errors++;
                $display("FAIL ovf_beat%0d: v=%b d=%h c=%0d s=%0d, want 1/%h/%0d/%0d",
                         i, tvalid, tdata, tdest, tuser, 16'hA000 + 16'(i), i % 4, i % 8);
            end
            @(negedge clk);
        end
        checks++;
        if (tvalid !== 1'b0 || level !== 5'd0 || drops !== 8'd2) begin
            errors++;
            $display("FAIL ovf_drain: tvalid=%b level=%0d drops=%0d, want 0/0/2", tvalid, level, drops);
        end
    endtask

    task automatic test_mid_reset;
        tready = 1'b0;
        for (int i = 0; i < 5; i++) write_word(8'h11, 1'b0, 3'd2, 16'hC000 + 16'(i));
        checks++;
        if (level !== 5'd5) begin
            errors++;
            $display("FAIL mrst_queued: level=%0d, want 5", level);
        end
        DIOA = 8'hD0; DIOB = 8'h0D; DIOC = 8'h11; DIOD = 8'h01;
        repeat (LAT + 2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (tvalid !== 1'b0 || level !== 5'd0 || drops !== 8'd0 || tdata !== 16'h0) begin
            errors++;
            $display("FAIL mrst_during: v=%b level=%0d drops=%0d d=%h, want 0/0/0/0", tvalid, level, drops, tdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL mrst_held: tvalid=%b level=%0d, want 0/0", tvalid, level);
        end
        DIOD[0] = 1'b0;
        repeat (4) @(negedge clk);
        write_word(8'h13, 1'b0, 3'd6, 16'h7E57);
        checks++;
        if (level !== 5'd1 || tdata !== 16'h7E57 || tdest !== 2'd3 || tuser !== 3'd6) begin
            errors++;
            $display("FAIL mrst_next: level=%0d d=%h c=%0d s=%0d, want 1/7e57/3/6", level, tdata, tdest, tuser);
        end
        tready = 1'b1;
        @(negedge clk);
        checks++;
        if (level !== 5'd0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL mrst_pop: level=%0d tvalid=%b, want 0/0", level, tvalid);
        end
    endtask

`ifdef LC_STROBE_FILTER_EN
    task automatic test_filter;
        tready = 1'b0;
        for (int w = 2; w <= 3; w++) begin
            @(negedge clk);
            DIOA = 8'h0F; DIOB = 8'hF0; DIOC = 8'h10; DIOD = 8'h01;
            repeat (w) @(negedge clk);
            DIOD[0] = 1'b0;
            repeat (8) @(negedge clk);
            checks++;
            if (level !== 5'(w - 2)) begin
                errors++;
                $display("FAIL filter_w%0d: level=%0d, want %0d", w, level, w - 2);
            end
        end
        tready = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1; tready = 1'b0;
        DIOA = 8'h00; DIOB = 8'h00; DIOC = 8'h00; DIOD = 8'h00;
        test_reset();
        test_single();
        test_reject();
        test_back_to_back();
        test_overflow();
        test_mid_reset();
`ifdef LC_STROBE_FILTER_EN
        test_filter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
